// File: rtl/regfile_scan_checker.sv
// Regfile scan checker: walks a table of {register, expected value, mask} entries and
// compares each against the register file. Optional macro SCAN_STOP_ON_FAIL_EN ends the scan at the first mismatch.
module regfile_scan_checker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int MAX_CHECKS = 16,
  parameter int RD_LAT     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_CHECKS)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]             cfg_reg,
  input  logic [DATA_W-1:0]             cfg_val,
  input  logic [DATA_W-1:0]             cfg_mask,
  input  logic [$clog2(MAX_CHECKS):0]   num_checks,
  input  logic                          start,
  output logic                          rf_test,
  output logic [ADDR_W-1:0]             rf_read_reg,
  input  logic [DATA_W-1:0]             rf_read_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(MAX_CHECKS):0]   num_correct,
  output logic [$clog2(MAX_CHECKS):0]   num_checked,
  output logic                          fail_seen,
  output logic [ADDR_W-1:0]             fail_reg,
  output logic [DATA_W-1:0]             fail_expected,
  output logic [DATA_W-1:0]             fail_actual
);

  localparam int IDX_W = $clog2(MAX_CHECKS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CHECKS);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       WAIT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_FINISH  = 3'd4
  } state_t;

  // An entry passes when no masked bit differs; a zero mask always passes.
  function automatic logic entry_pass(input logic [DATA_W-1:0] actual,
                                      input logic [DATA_W-1:0] expected,
                                      input logic [DATA_W-1:0] mask);
    return ((actual ^ expected) & mask) == {DATA_W{1'b0}};
  endfunction

  logic [ADDR_W-1:0] tbl_reg_r  [MAX_CHECKS];
  logic [DATA_W-1:0] tbl_val_r  [MAX_CHECKS];
  logic [DATA_W-1:0] tbl_mask_r [MAX_CHECKS];

  state_t            state_r;
  logic [CNT_W-1:0]  ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [2:0]        wait_cnt_r;
  logic              busy_r;
  logic              done_r;
  logic [ADDR_W-1:0] rd_reg_r;
  logic [CNT_W-1:0]  correct_r;
  logic [CNT_W-1:0]  checked_r;
  logic              fail_seen_r;
  logic [ADDR_W-1:0] fail_reg_r;
  logic [DATA_W-1:0] fail_exp_r;
  logic [DATA_W-1:0] fail_act_r;

  logic [IDX_W-1:0]  ptr_idx_s;
  logic [CNT_W-1:0]  next_ptr_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic [CNT_W-1:0]  sat_count_s;
  logic              pass_s;
  logic              stop_s;

  // Check table: no reset so contents survive a reset; writes locked out while scanning.
  always_ff @(posedge clock) begin
    if (!reset && cfg_we && !busy_r) begin
      tbl_reg_r[cfg_idx]  <= cfg_reg;
      tbl_val_r[cfg_idx]  <= cfg_val;
      tbl_mask_r[cfg_idx] <= cfg_mask;
    end
  end

  // Entry selection, count saturation and the per-entry verdict.
  always_comb begin
    ptr_idx_s   = ptr_r[IDX_W-1:0];
    next_ptr_s  = ptr_r + CNT_ONE;
    next_idx_s  = next_ptr_s[IDX_W-1:0];
    if (num_checks > MAX_CNT) begin
      sat_count_s = MAX_CNT;
    end else begin
      sat_count_s = num_checks;
    end
    pass_s = entry_pass(rf_read_data, tbl_val_r[ptr_idx_s], tbl_mask_r[ptr_idx_s]);
`ifdef SCAN_STOP_ON_FAIL_EN
    stop_s = !pass_s;
`else
    stop_s = 1'b0;
`endif
  end

  // Scan sequencer with all outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= CNT_ZERO;
      count_r     <= CNT_ZERO;
      wait_cnt_r  <= 3'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_reg_r    <= {ADDR_W{1'b0}};
      correct_r   <= CNT_ZERO;
      checked_r   <= CNT_ZERO;
      fail_seen_r <= 1'b0;
      fail_reg_r  <= {ADDR_W{1'b0}};
      fail_exp_r  <= {DATA_W{1'b0}};
      fail_act_r  <= {DATA_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            count_r     <= sat_count_s;
            ptr_r       <= CNT_ZERO;
            correct_r   <= CNT_ZERO;
            checked_r   <= CNT_ZERO;
            fail_seen_r <= 1'b0;
            fail_reg_r  <= {ADDR_W{1'b0}};
            fail_exp_r  <= {DATA_W{1'b0}};
            fail_act_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b1;
            if (sat_count_s == CNT_ZERO) begin
              state_r <= ST_FINISH;
              done_r  <= 1'b1;
            end else begin
              state_r  <= ST_ISSUE;
              rd_reg_r <= tbl_reg_r[0];
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (RD_LAT == 0) begin
            state_r <= ST_COMPARE;
          end else begin
            wait_cnt_r <= WAIT_INIT;
            state_r    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == 3'd0) begin
            state_r <= ST_COMPARE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 3'd1;
          end
        end
        ST_COMPARE: begin
          checked_r <= checked_r + CNT_ONE;
          if (pass_s) begin
            correct_r <= correct_r + CNT_ONE;
          end else if (!fail_seen_r) begin
            fail_seen_r <= 1'b1;
            fail_reg_r  <= tbl_reg_r[ptr_idx_s];
            fail_exp_r  <= tbl_val_r[ptr_idx_s];
            fail_act_r  <= rf_read_data;
          end
          ptr_r <= next_ptr_s;
          // rd_reg_r is only reloaded here so the address stays stable through WAIT.
          if ((next_ptr_s < count_r) && !stop_s) begin
            state_r  <= ST_ISSUE;
            rd_reg_r <= tbl_reg_r[next_idx_s];
          end else begin
            state_r <= ST_FINISH;
            done_r  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_r;
  assign rf_test       = busy_r;
  assign done          = done_r;
  assign rf_read_reg   = rd_reg_r;
  assign num_correct   = correct_r;
  assign num_checked   = checked_r;
  assign fail_seen     = fail_seen_r;
  assign fail_reg      = fail_reg_r;
  assign fail_expected = fail_exp_r;
  assign fail_actual   = fail_act_r;

endmodule
